// File: rtl/event_blinker.sv
// Turns single-cycle event strobes into fixed-length LED blinks with a guaranteed off-time.
// Strobes that arrive mid-blink are queued in a saturating counter and replayed back-to-back.
module event_blinker #(
    parameter int TICK_DIV  = 100000,
    parameter int ON_TICKS  = 250,
    parameter int OFF_TICKS = 250,
    parameter int PEND_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              event_in,
    input  logic              clr_ovf,
    output logic              led,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int PSC_W  = $clog2(TICK_DIV);
    localparam int T_MAX  = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TCNT_W = $clog2(T_MAX + 1);

    localparam logic [PSC_W-1:0]  PSC_LAST = PSC_W'(TICK_DIV - 1);
    localparam logic [TCNT_W-1:0] ON_LAST  = TCNT_W'(ON_TICKS - 1);
    localparam logic [TCNT_W-1:0] OFF_LAST = TCNT_W'(OFF_TICKS - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_OFF
    } state_t;

    state_t              r_state;
    logic [PSC_W-1:0]    r_psc;
    logic [TCNT_W-1:0]   r_tcnt;
    logic [PEND_W-1:0]   r_pend;
    logic                r_led;
    logic                r_busy;
    logic                r_ovf;

    state_t              w_state_nxt;
    logic                w_tick;
    logic                w_avail;
    logic                w_accept;
    logic                w_drop;
    logic [PEND_W-1:0]   w_pend_nxt;

    assign w_tick  = (r_state != S_IDLE) && (r_psc == PSC_LAST);
    assign w_avail = event_in || (r_pend != '0);

    // w_accept marks the edges where a new blink may start: all of IDLE and the
    // terminal OFF tick, which lets queued blinks run with no idle gap.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_drop      = 1'b0;
        w_pend_nxt  = r_pend;
        case (r_state)
            S_IDLE:  w_accept = 1'b1;
            S_ON:    if (w_tick && (r_tcnt == ON_LAST)) w_state_nxt = S_OFF;
            S_OFF:   if (w_tick && (r_tcnt == OFF_LAST)) w_accept = 1'b1;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_accept) begin
            w_state_nxt = w_avail ? S_ON : S_IDLE;
            if ((r_pend != '0) && !event_in)
                w_pend_nxt = r_pend - PEND_W'(1);
        end else if (event_in) begin
            if (r_pend == PEND_MAX)
                w_drop = 1'b1;
            else
                w_pend_nxt = r_pend + PEND_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_psc   <= '0;
            r_tcnt  <= '0;
            r_pend  <= '0;
            r_led   <= 1'b0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_led   <= (w_state_nxt == S_ON);
            r_busy  <= (w_state_nxt != S_IDLE);
            r_pend  <= w_pend_nxt;

            if ((r_state == S_IDLE) || w_tick)
                r_psc <= '0;
            else
                r_psc <= r_psc + PSC_W'(1);

            if (w_state_nxt != r_state)
                r_tcnt <= '0;
            else if (w_tick)
                r_tcnt <= r_tcnt + TCNT_W'(1);

            if (w_drop)
                r_ovf <= 1'b1;
            else if (clr_ovf)
                r_ovf <= 1'b0;
        end
    end

    assign led      = r_led;
    assign busy     = r_busy;
    assign pending  = r_pend;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_event_blinker.sv
// Bench for event_blinker: cycle-count reference model compared every cycle,
// directed scenarios with literal expectations, then randomized strobes and resets.
module tb_event_blinker;

    localparam int TD      = 4;
    localparam int ON_T    = 2;
    localparam int OFF_T   = 3;
    localparam int PW      = 2;
    localparam int ON_CYC  = ON_T * TD;
    localparam int OFF_CYC = OFF_T * TD;
    localparam int PMAX    = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          event_in = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          led;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;

    event_blinker #(
        .TICK_DIV (TD),
        .ON_TICKS (ON_T),
        .OFF_TICKS(OFF_T),
        .PEND_W   (PW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .event_in(event_in),
        .clr_ovf (clr_ovf),
        .led     (led),
        .busy    (busy),
        .pending (pending),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a blink is a phase with a number of clk cycles left,
    // no prescaler or tick counter involved.
    int m_phase = 0;   // 0 idle, 1 on, 2 off
    int m_left  = 0;
    int m_pend  = 0;
    bit m_ovf   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        bit accept;
        bit drop;
        if (!rst_n) begin
            m_phase = 0; m_left = 0; m_pend = 0; m_ovf = 1'b0;
        end else begin
            accept = 1'b0;
            drop   = 1'b0;
            if (m_phase == 0) accept = 1'b1;
            else if (m_phase == 2 && m_left == 1) accept = 1'b1;
            else if (m_phase == 1 && m_left == 1) begin m_phase = 2; m_left = OFF_CYC; end
            else m_left--;

            if (accept) begin
                if (event_in || m_pend > 0) begin
                    m_phase = 1;
                    m_left  = ON_CYC;
                    if (m_pend > 0 && !event_in) m_pend--;
                end else begin
                    m_phase = 0;
                end
            end else if (event_in) begin
                if (m_pend == PMAX) drop = 1'b1;
                else m_pend++;
            end

            if (drop) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_led",      led,      (m_phase == 1));
            chk("cmp_busy",     busy,     (m_phase != 0));
            chk("cmp_pending",  pending,  m_pend);
            chk("cmp_overflow", overflow, m_ovf);
        end
    end

    int led_cyc = 0;
    int busy_cyc = 0;
    int rises = 0;
    logic led_q = 1'b0;
    always @(negedge clk) begin
        if (led === 1'b1) led_cyc++;
        if (busy === 1'b1) busy_cyc++;
        if (led === 1'b1 && led_q !== 1'b1) rises++;
        led_q = led;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int n);
        event_in = 1'b1;
        tick(n);
        event_in = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) chk("idle_timeout", busy, 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, l0, b0, thr;

        #2;
        chk("rst_led", led, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pending", pending, 0);
        chk("rst_overflow", overflow, 0);
        #10 rst_n = 1'b1;
        cmp_en = 1'b1;
        tick(2);

        // single strobe
        r0 = rises; l0 = led_cyc; b0 = busy_cyc;
        pulse(1);
        wait_idle(100);
        chk("single_led_cycles", led_cyc - l0, 8);
        chk("single_busy_cycles", busy_cyc - b0, 20);
        chk("single_blinks", rises - r0, 1);

        // queued events: one start plus three strobes during ON
        tick(2);
        r0 = rises; b0 = busy_cyc;
        pulse(4);
        chk("queue_pending", pending, 3);
        chk("queue_model_pend", m_pend, 3);
        wait_idle(200);
        chk("queue_blinks", rises - r0, 4);
        chk("queue_busy_cycles", busy_cyc - b0, 80);

        // saturation, clear, and set-wins-over-clear
        tick(2);
        r0 = rises;
        pulse(6);
        chk("sat_pending", pending, 3);
        chk("sat_overflow", overflow, 1);
        clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
        chk("sat_clr", overflow, 0);
        clr_ovf = 1'b1; event_in = 1'b1; tick(1); clr_ovf = 1'b0; event_in = 1'b0;
        chk("sat_set_wins", overflow, 1);
        chk("sat_pending_hold", pending, 3);
        wait_idle(200);
        chk("sat_blinks", rises - r0, 4);
        clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;

        // strobe on the terminal OFF edge starts a blink immediately
        tick(2);
        pulse(1);
        tick(19);
        pulse(1);
        chk("term_led", led, 1);
        chk("term_busy", busy, 1);
        chk("term_pending", pending, 0);
        wait_idle(100);

        // asynchronous reset 3 cycles into ON with two queued
        tick(2);
        pulse(3);
        chk("rstmid_pending_pre", pending, 2);
        tick(1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_led", led, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_pending", pending, 0);
        #2 rst_n = 1'b1;
        tick(1);
        l0 = led_cyc;
        pulse(1);
        wait_idle(100);
        chk("rstmid_full_on", led_cyc - l0, 8);

        // level input held three cycles while idle
        tick(2);
        r0 = rises;
        pulse(3);
        chk("level_pending", pending, 2);
        wait_idle(200);
        chk("level_blinks", rises - r0, 3);

        // randomized strobes, clears and occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            thr = ((i / 500) % 3 == 0) ? 1 : (((i / 500) % 3 == 1) ? 7 : 39);
            event_in = ($urandom_range(0, thr) == 0);
            clr_ovf  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        event_in = 1'b0;
        clr_ovf  = 1'b0;
        wait_idle(400);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/event_blinker.md
Name: event_blinker

Overview:
- Output-side counterpart to the input debouncers in the slot machine design.
- A debouncer removes short glitches from a raw human input. This block does the opposite: it turns single-cycle internal strobes (win, coin, spin-start) into human-visible LED blinks.
- Each accepted strobe produces exactly one blink of fixed on-time, followed by a guaranteed minimum off-time.
- Strobes that arrive while a blink is in progress are queued in a saturating pending counter, so none are merged or lost until saturation.

Parameters:
- TICK_DIV, 100000, clk cycles per timing tick (prescaler terminal count + 1); must be ≥2.
- ON_TICKS, 250, ticks the LED is held high per blink; must be ≥1.
- OFF_TICKS, 250, minimum ticks the LED is held low after each blink; must be ≥1.
- PEND_W, 4, width of the pending-event counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- event_in  input  1  single-cycle event strobe, sampled on rising clk. Level-high for N cycles counts as N events.
- clr_ovf  input  1  synchronous clear of the overflow flag.
- led  output  1  registered blink output.
- busy  output  1  high when state is not IDLE.
- pending  output  PEND_W  queued events not yet started.
- overflow  output  1  sticky flag: an event was dropped because pending was saturated.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; led=0, busy=0, pending=0, overflow=0.
  - Prescaler and tick counter cleared.
  - Reset during ON or OFF aborts the blink immediately; led drops without waiting for a clk edge.
- Prescaler: counts 0..TICK_DIV-1 only while state is ON or OFF, and is held at 0 in IDLE. A tick is one cycle where prescaler==TICK_DIV-1.
- Tick counter: cleared on every state entry; increments on each tick.
- State IDLE:
  - On an edge where event_in=1 or pending>0: go to ON and set led=1 at that edge.
  - If pending>0, the queued event is consumed (pending-1) and a simultaneous event_in is queued (pending+1), so pending is unchanged net.
  - If pending==0, event_in is consumed directly.
- State ON:
  - led=1 for exactly ON_TICKS*TICK_DIV cycles.
  - On the ON_TICKS-th tick: go to OFF, led=0.
- State OFF:
  - led=0 for exactly OFF_TICKS*TICK_DIV cycles.
  - On the OFF_TICKS-th tick the block applies the IDLE accept rule at that same edge. If an event is available (pending>0 or event_in=1), it goes directly to ON with no idle gap; otherwise it goes to IDLE.
  - Back-to-back blink period is therefore (ON_TICKS+OFF_TICKS)*TICK_DIV cycles.
- Queueing:
  - event_in=1 while the block is not accepting it (ON, or OFF before its terminal tick): pending+1.
  - If pending is already 2^PEND_W-1, pending holds and overflow is set.
- Overflow:
  - Sticky; cleared only by clr_ovf=1 or reset.
  - If set and clear occur on the same edge, set wins.
- busy = (state != IDLE); registered together with state.
- Width rules:
  - Prescaler sized for TICK_DIV-1; tick counter sized for max(ON_TICKS, OFF_TICKS).
  - No wrap-around is permitted in either counter.
  - pending never underflows, since consume only occurs when pending>0.

Test Plan (TICK_DIV=4, ON_TICKS=2, OFF_TICKS=3, PEND_W=2 unless stated):
- Single strobe:
  - Stimulus: event_in pulsed for 1 cycle at edge k.
  - Response: led=1 for edges k..k+7 (8 cycles), then led=0 for 12 cycles; busy=1 for 20 cycles then 0; pending stays 0.
- Queued events:
  - Stimulus: 3 strobes during the first blink's ON phase.
  - Response: pending reads 3; 4 blinks total with 20-cycle period and no idle cycle between them; pending steps 3→2→1→0 at each new ON entry.
- Saturation:
  - Stimulus: 5 strobes while busy.
  - Response: pending=3, overflow=1, 4 blinks total.
  - Then pulse clr_ovf: overflow=0.
  - Then assert clr_ovf on the same edge as a dropped strobe: overflow stays 1.
- Terminal-edge strobe:
  - Stimulus: event_in on the final OFF tick edge with pending=0.
  - Response: ON entered at that edge, led=1, pending remains 0.
- Reset mid-blink:
  - Stimulus: drop rst_n 3 cycles into ON with pending=2.
  - Response: led=0, busy=0, pending=0 immediately, without a clk edge.
  - After release, a strobe produces a full 8-cycle on-time.
- Level input:
  - Stimulus: event_in held high 3 cycles while IDLE.
  - Response: the first cycle starts a blink; pending ends at 2; 3 blinks total.
